// File: rtl/uart_irq_pkg.sv
// Shared types and constants for the UART interrupt scheduler.
// Build option: UART_IRQ_RR_EN selects round-robin arbitration instead of fixed priority.
package uart_irq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int SRC_TXTHR = 0;
   localparam int SRC_RXTHR = 1;
   localparam int SRC_PE    = 2;
   localparam int SRC_FRE   = 3;
   localparam int SRC_RXOV  = 4;

   localparam int NSRC_DEF  = 5;

endpackage

// File: rtl/uart_irq_pick.sv
// Combinational winner select over the pending bits.
// Build option: UART_IRQ_RR_EN -> search starts at ptr_i and wraps; otherwise highest index wins
// and ptr_i is ignored.
module uart_irq_pick
   import uart_irq_pkg::*;
#(
   parameter int NSRC = NSRC_DEF,
   parameter int IDW  = 3
) (
   input  logic [NSRC-1:0] pend_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic            valid_o,
   output logic [IDW-1:0]  id_o
);

`ifdef UART_IRQ_RR_EN
   logic            found;
   int              idx;
   logic [NSRC-1:0] rot;

   // Walk the sources starting at the pointer; the first pending one found wins.
   always_comb begin
      valid_o = |pend_i;
      id_o    = '0;
      found   = 1'b0;
      idx     = 0;
      rot     = '0;
      for (int k = 0; k < NSRC; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= NSRC) begin
            idx = idx - NSRC;
         end
         rot = pend_i >> idx;
         if (!found && rot[0]) begin
            found = 1'b1;
            id_o  = IDW'(idx);
         end
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;

   // Scan upward so the highest pending index overwrites any lower one.
   always_comb begin
      valid_o = |pend_i;
      id_o    = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (pend_i[i]) begin
            id_o = IDW'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/uart_irq_scheduler.sv
// Turns masked UART interrupt source edges into sticky pending bits and presents them one at a
// time on a single CPU interrupt line, with a hold-off gap after each acknowledge.
// Build option: UART_IRQ_RR_EN enables round-robin arbitration with a rotating pointer.
module uart_irq_scheduler
   import uart_irq_pkg::*;
#(
   parameter int NSRC    = NSRC_DEF,
   parameter int IDW     = 3,
   parameter int HOLDOFF = 2
) (
   input  logic            pclk,
   input  logic            preset,
   input  logic [NSRC-1:0] src_i,
   input  logic            irq_ack_i,
   input  logic            lost_clr_i,
   output logic            irq_o,
   output logic [IDW-1:0]  irq_id_o,
   output logic [NSRC-1:0] pend_o,
   output logic [NSRC-1:0] lost_o,
   output logic            busy_o
);

   // A zero-width counter is illegal, so HOLDOFF=0 still gets one (never loaded) bit.
   localparam int            CW        = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

   logic [NSRC-1:0] src_q;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] lost_q, lost_d;
   logic [NSRC-1:0] edge_det;
   logic [NSRC-1:0] clr_mask;
   logic            ack_take;

   state_t          state_q, state_d;
   logic            irq_q, irq_d;
   logic [IDW-1:0]  id_q, id_d;
   logic            busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IDW-1:0]  ptr_q, ptr_d;

   logic            pick_valid;
   logic [IDW-1:0]  pick_id;

   uart_irq_pick #(
      .NSRC (NSRC),
      .IDW  (IDW)
   ) u_pick (
      .pend_i  (pend_q),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .id_o    (pick_id)
   );

   // Pending bits: a fresh edge beats a same-cycle ack clear, and an edge landing on a bit that
   // stays pending is recorded as lost; a new loss also beats lost_clr_i.
   always_comb begin
      edge_det = src_i & ~src_q;
      ack_take = (state_q == REQ) && irq_ack_i;
      clr_mask = ack_take ? (NSRC'(1) << id_q) : '0;
      pend_d   = (pend_q & ~clr_mask) | edge_det;
      lost_d   = (lost_clr_i ? '0 : lost_q) | (edge_det & pend_q & ~clr_mask);
   end

   // Next-state logic for the grant FSM, its hold-off counter and the round-robin pointer.
   always_comb begin
      state_d = state_q;
      irq_d   = irq_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               id_d    = pick_id;
               irq_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (irq_ack_i) begin
               irq_d = 1'b0;
`ifdef UART_IRQ_RR_EN
               ptr_d = (id_q == IDW'(NSRC - 1)) ? '0 : id_q + 1'b1;
`endif
               if (HOLDOFF == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = HOLD;
                  cnt_d   = HOLD_LOAD;
               end
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Edge history and the pending/lost registers.
   always_ff @(posedge pclk) begin
      if (preset) begin
         src_q  <= '0;
         pend_q <= '0;
         lost_q <= '0;
      end else begin
         src_q  <= src_i;
         pend_q <= pend_d;
         lost_q <= lost_d;
      end
   end

   // Grant FSM with registered outputs; reset aborts any grant in flight.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= IDLE;
         irq_q   <= 1'b0;
         id_q    <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         irq_q   <= irq_d;
         id_q    <= id_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign irq_o    = irq_q;
   assign irq_id_o = id_q;
   assign pend_o   = pend_q;
   assign lost_o   = lost_q;
   assign busy_o   = busy_q;

endmodule
